wb_arbiter: RTL

- Writeback stage directly downstream of the functional units (ALU, branch, memory).
- Buffers completed results per source and selects the oldest result by ROB age each cycle.
- Drives the single common data bus (CDB) that feeds PRF write, RS wakeup and ROB completion.
- Discards wrong-path results on branch mispredict and back-pressures the reservation stations before buffers overflow.

---
 rtl/wb_arbiter_pkg.sv | 37 +++
 rtl/wb_slot_buf.sv | 77 +++++++
 rtl/wb_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : wb_arbiter_pkg
// Desc   : Shared types, widths and ROB-age helpers for the writeback arbiter.
// Rev    : 1.0
// ============================================================================
package wb_arbiter_pkg;

    localparam int ROB_W      = 5;
    localparam int PREG_W     = 7;
    localparam int WB_ENTRY_W = ROB_W + PREG_W + 1 + 32;

    localparam logic [1:0] WB_SRC_ALU = 2'd0;
    localparam logic [1:0] WB_SRC_BR  = 2'd1;
    localparam logic [1:0] WB_SRC_MEM = 2'd2;

    typedef struct packed {
        logic [ROB_W-1:0]  rob_tag;
        logic [PREG_W-1:0] pd;
        logic              we;
        logic [31:0]       data;
    } wb_entry_t;

    function automatic logic [ROB_W-1:0] rob_age(input logic [ROB_W-1:0] tag,
                                                 input logic [ROB_W-1:0] head);
        return tag - head;
    endfunction

    // Younger than the mispredicted branch; the branch itself survives.
    function automatic logic rob_killed(input logic [ROB_W-1:0] tag,
                                        input logic [ROB_W-1:0] br_tag,
                                        input logic [ROB_W-1:0] head);
        return rob_age(tag, head) > rob_age(br_tag, head);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_slot_buf.sv
`default_nettype none
// ============================================================================
// Module : wb_slot_buf
// Desc   : Unordered per-source result buffer with flush kill, stall, overflow.
// Rev    : 1.0
// ============================================================================
module wb_slot_buf
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_valid,
    input  logic [WB_ENTRY_W-1:0]       i_entry,
    input  logic                        i_bypass,
    input  logic [DEPTH-1:0]            i_free_mask,
    input  logic                        i_mispredict,
    input  logic [ROB_W-1:0]            i_mispredict_tag,
    input  logic [ROB_W-1:0]            i_rob_head,
    output logic [DEPTH-1:0]            o_slot_valid,
    output logic [DEPTH*WB_ENTRY_W-1:0] o_slot_entry,
    output logic                        o_stall,
    output logic                        o_overflow
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        w_in;
    wb_entry_t        r_entry [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] w_kill;
    logic [DEPTH-1:0] w_wr_onehot;
    logic [CNT_W-1:0] w_count;
    logic             w_in_killed;
    logic             w_full;
    logic             w_wr;

    assign w_in        = wb_entry_t'(i_entry);
    assign w_in_killed = i_mispredict && rob_killed(w_in.rob_tag, i_mispredict_tag, i_rob_head);
    assign w_full      = &r_valid;
    assign w_wr        = i_valid && !w_in_killed && !w_full && !i_bypass;
    // One-hot of the lowest clear bit in r_valid.
    assign w_wr_onehot = ~r_valid & (r_valid + DEPTH'(1));
    assign o_overflow  = i_valid && !w_in_killed && w_full;

    always_comb begin
        w_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_count = w_count + CNT_W'(r_valid[i]);
        end
    end

    assign o_stall = (w_count >= CNT_W'(DEPTH - 2));

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        assign w_kill[i] = i_mispredict && rob_killed(r_entry[i].rob_tag, i_mispredict_tag, i_rob_head);
        assign o_slot_entry[i*WB_ENTRY_W +: WB_ENTRY_W] = r_entry[i];

        always_ff @(posedge clk) begin
            if (w_wr && w_wr_onehot[i]) begin
                r_entry[i] <= w_in;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
        end else begin
            r_valid <= (r_valid & ~i_free_mask & ~w_kill) | (w_wr ? w_wr_onehot : '0);
        end
    end

    assign o_slot_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module : wb_arbiter
// Desc   : Oldest-first writeback arbiter driving the CDB from ALU/BR/MEM.
//          Optional same-cycle bypass of empty buffers: define WB_BYPASS_EN.
// Rev    : 1.0
// ============================================================================
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [ROB_W-1:0]  alu_rob_tag,
    input  logic [PREG_W-1:0] alu_pd,
    input  logic              alu_we,
    input  logic [31:0]       alu_data,
    input  logic              b_valid,
    input  logic [ROB_W-1:0]  b_rob_tag,
    input  logic [PREG_W-1:0] b_pd,
    input  logic              b_we,
    input  logic [31:0]       b_data,
    input  logic              mem_valid,
    input  logic [ROB_W-1:0]  mem_rob_tag,
    input  logic [PREG_W-1:0] mem_pd,
    input  logic              mem_we,
    input  logic [31:0]       mem_data,
    input  logic [ROB_W-1:0]  rob_head,
    input  logic              mispredict,
    input  logic [ROB_W-1:0]  mispredict_tag,
    output logic              cdb_valid,
    output logic [ROB_W-1:0]  cdb_rob_tag,
    output logic [PREG_W-1:0] cdb_pd,
    output logic              cdb_we,
    output logic [31:0]       cdb_data,
    output logic [1:0]        cdb_src,
    output logic              alu_stall,
    output logic              b_stall,
    output logic              mem_stall,
    output logic              overflow_err
);
    localparam int N_SRC  = 3;
    localparam int N_SLOT = N_SRC * DEPTH;
`ifdef WB_BYPASS_EN
    localparam int N_CAND = N_SLOT + N_SRC;
`else
    localparam int N_CAND = N_SLOT;
`endif

    logic [WB_ENTRY_W-1:0]        w_in_vec [N_SRC];
    logic [N_SRC-1:0]             w_in_valid;
    logic [N_SRC-1:0]             w_bypass;
    logic [N_SRC-1:0]             w_stall;
    logic [N_SRC-1:0]             w_ovf;
    logic [N_SLOT-1:0]            w_slot_valid;
    logic [N_SLOT*WB_ENTRY_W-1:0] w_slot_flat;
    logic [N_CAND-1:0]            w_cand_valid;
    wb_entry_t                    w_cand_entry [N_CAND];
    logic [1:0]                   w_cand_src   [N_CAND];
    logic [N_CAND-1:0]            w_sel_onehot;
    logic                         w_sel_valid;
    wb_entry_t                    w_sel_entry;
    logic [1:0]                   w_sel_src;
    logic [ROB_W-1:0]             w_sel_age;
    logic                         r_cdb_valid;
    wb_entry_t                    r_cdb_entry;
    logic [1:0]                   r_cdb_src;
    logic                         r_overflow;

    assign w_in_valid  = {mem_valid, b_valid, alu_valid};
    assign w_in_vec[0] = {alu_rob_tag, alu_pd, alu_we, alu_data};
    assign w_in_vec[1] = {b_rob_tag, b_pd, b_we, b_data};
    assign w_in_vec[2] = {mem_rob_tag, mem_pd, mem_we, mem_data};

    for (genvar s = 0; s < N_SRC; s++) begin : g_buf
        wb_slot_buf #(
            .DEPTH (DEPTH)
        ) u_slot_buf (
            .clk              (clk),
            .reset            (reset),
            .i_valid          (w_in_valid[s]),
            .i_entry          (w_in_vec[s]),
            .i_bypass         (w_bypass[s]),
            .i_free_mask      (w_sel_onehot[s*DEPTH +: DEPTH]),
            .i_mispredict     (mispredict),
            .i_mispredict_tag (mispredict_tag),
            .i_rob_head       (rob_head),
            .o_slot_valid     (w_slot_valid[s*DEPTH +: DEPTH]),
            .o_slot_entry     (w_slot_flat[s*DEPTH*WB_ENTRY_W +: DEPTH*WB_ENTRY_W]),
            .o_stall          (w_stall[s]),
            .o_overflow       (w_ovf[s])
        );

        for (genvar i = 0; i < DEPTH; i++) begin : g_slot
            assign w_cand_entry[s*DEPTH+i] = wb_entry_t'(w_slot_flat[(s*DEPTH+i)*WB_ENTRY_W +: WB_ENTRY_W]);
            assign w_cand_src[s*DEPTH+i]   = 2'(s);
        end

`ifdef WB_BYPASS_EN
        // An input may race the buffered entries only while its own buffer is empty.
        assign w_cand_entry[N_SLOT+s] = wb_entry_t'(w_in_vec[s]);
        assign w_cand_src[N_SLOT+s]   = 2'(s);
        assign w_cand_valid[N_SLOT+s] = w_in_valid[s] && !(|w_slot_valid[s*DEPTH +: DEPTH]);
        assign w_bypass[s]            = w_sel_onehot[N_SLOT+s];
`else
        assign w_bypass[s] = 1'b0;
`endif
    end

    assign w_cand_valid[N_SLOT-1:0] = w_slot_valid;

    always_comb begin
        w_sel_valid  = 1'b0;
        w_sel_onehot = '0;
        w_sel_entry  = '0;
        w_sel_src    = WB_SRC_ALU;
        w_sel_age    = '0;
        for (int i = 0; i < N_CAND; i++) begin
            if (w_cand_valid[i]
                && !(mispredict && rob_killed(w_cand_entry[i].rob_tag, mispredict_tag, rob_head))
                && (!w_sel_valid || rob_age(w_cand_entry[i].rob_tag, rob_head) < w_sel_age)) begin
                w_sel_valid     = 1'b1;
                w_sel_onehot    = '0;
                w_sel_onehot[i] = 1'b1;
                w_sel_entry     = w_cand_entry[i];
                w_sel_src       = w_cand_src[i];
                w_sel_age       = rob_age(w_cand_entry[i].rob_tag, rob_head);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cdb_valid <= 1'b0;
            r_cdb_entry <= '0;
            r_cdb_src   <= WB_SRC_ALU;
            r_overflow  <= 1'b0;
        end else begin
            r_cdb_valid <= w_sel_valid;
            if (w_sel_valid) begin
                r_cdb_entry <= w_sel_entry;
                r_cdb_src   <= w_sel_src;
            end
            if (|w_ovf) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign cdb_valid    = r_cdb_valid
                          && !(mispredict && rob_killed(r_cdb_entry.rob_tag, mispredict_tag, rob_head));
    assign cdb_rob_tag  = r_cdb_entry.rob_tag;
    assign cdb_pd       = r_cdb_entry.pd;
    assign cdb_we       = r_cdb_entry.we;
    assign cdb_data     = r_cdb_entry.data;
    assign cdb_src      = r_cdb_src;
    assign alu_stall    = w_stall[0];
    assign b_stall      = w_stall[1];
    assign mem_stall    = w_stall[2];
    assign overflow_err = r_overflow;

endmodule
`default_nettype wire
